// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared state encodings and default width for add_sequencer
package add_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int STATE_W       = 3;

    localparam logic [STATE_W-1:0] ST_LOAD_A = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_A = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD_B = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_B = 3'd3;
    localparam logic [STATE_W-1:0] ST_ADD    = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

    // Idle states are the ones waiting for an operator press with nothing in flight
    function automatic logic state_busy(input logic [STATE_W-1:0] st);
        return !((st == ST_LOAD_A) || (st == ST_DONE));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - operator-driven operand loader and result capture for an external adder
module add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             accumulate,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             c_out_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             c_in_out,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             busy,
    output logic [2:0]       state_out
);

    logic                go_s;
    logic [STATE_W-1:0]  state;

    sync_2ff u_go_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (go),
        .q      (go_s)
    );

    // Status outputs decode straight from the state register so they clear with it on reset
    assign result_valid = (state == ST_DONE);
    assign busy         = state_busy(state);
    assign state_out    = state;

    // Sequencer: each press captures one operand, each release arms the next step
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_LOAD_A;
            a_out    <= '0;
            b_out    <= '0;
            c_in_out <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                ST_LOAD_A: begin
                    if (go_s) begin
                        a_out <= data_in;
                        state <= ST_WAIT_A;
                    end
                end
                ST_WAIT_A: begin
                    if (!go_s) state <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    if (go_s) begin
                        b_out    <= data_in;
                        c_in_out <= carry_in;
                        state    <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (!go_s) state <= ST_ADD;
                end
                ST_ADD: begin
                    // Operands have been stable for a full cycle, so the external sum has settled
                    result <= {c_out_in, sum_in};
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (go_s) begin
                        if (accumulate) begin
                            a_out    <= result[WIDTH-1:0];
                            b_out    <= data_in;
                            c_in_out <= carry_in;
                            state    <= ST_WAIT_B;
                        end else begin
                            a_out <= data_in;
                            state <= ST_WAIT_A;
                        end
                    end
                end
                default: state <= ST_LOAD_A;
            endcase
        end
    end

endmodule
